serial_sub: RTL and testbench

- Bit-serial subtractor computing diff = a - b - b_in, LSB first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop.
- Counterpart to the team's combinational ripple adder: same operand and carry/borrow conventions, but the inverse operation, time-multiplexed instead of unrolled.
- Used where area matters more than latency, e.g. sequential ALU paths and multi-cycle compare/decrement units.

---
 rtl/serial_sub_if.sv | 33 +++
 rtl/serial_sub.sv | 106 ++++++++++
 tb/tb_serial_sub.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/serial_sub_if.sv
// Handshake/operand bundle for serial_sub.
// SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
interface serial_sub_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;
`endif

   modport master (
      output start, a, b, b_in,
      input  busy, done, diff, borrow
`ifdef SERIAL_SUB_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  start, a, b, b_in,
      output busy, done, diff, borrow
`ifdef SERIAL_SUB_OVF_EN
      , output ovf
`endif
   );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - b_in, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub #(
   parameter int WIDTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   serial_sub_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             br_ff;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] diff_r;
   logic             borrow_r;
   logic             last;
   logic             x;
   logic             y;
   logic             d;
   logic             br_next;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_r;
`endif

   // Single full-subtractor cell fed from the shift register LSBs.
   always_comb begin
      x       = a_sr[0];
      y       = b_sr[0];
      d       = x ^ y ^ br_ff;
      br_next = (~x & y) | (~(x ^ y) & br_ff);
      last    = (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = RUN;
         RUN:     if (last) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr     <= '0;
         b_sr     <= '0;
         br_ff    <= 1'b0;
         cnt      <= '0;
         diff_r   <= '0;
         borrow_r <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_r    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_sr  <= bus.a;
                  b_sr  <= bus.b;
                  br_ff <= bus.b_in;
                  cnt   <= '0;
               end
            end
            RUN: begin
               diff_r <= {d, diff_r[WIDTH-1:1]};
               a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
               br_ff  <= br_next;
               cnt    <= cnt + CW'(1);
               if (last) begin
                  borrow_r <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                  // On the MSB cell br_ff is the borrow in, br_next the borrow out.
                  ovf_r    <= br_ff ^ br_next;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = (state != IDLE);
   assign bus.done   = (state == DONE);
   assign bus.diff   = diff_r;
   assign bus.borrow = borrow_r;
`ifdef SERIAL_SUB_OVF_EN
   assign bus.ovf    = ovf_r;
`endif
endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub (WIDTH=4).
module tb_serial_sub;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   serial_sub_if #(.WIDTH(4)) bus ();

   serial_sub #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulses start with the given operands and waits (bounded) for done.
   // Returns number of edges from the accepting edge up to done, inclusive.
   task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic bi,
                        output int cycles);
      int n;
      bus.a = a; bus.b = b; bus.b_in = bi; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 1;
      while (bus.done !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      cycles = n;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.start = 1'b0; bus.a = 4'hA; bus.b = 4'h3; bus.b_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      total++; if (bus.diff !== 4'b0000) begin bad++; $display("FAIL reset_diff got=%b exp=0000", bus.diff); end
      total++; if (bus.borrow !== 1'b0) begin bad++; $display("FAIL reset_borrow got=%b exp=0", bus.borrow); end
      // reset and start together: start dropped
      bus.start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; bus.start = 1'b0;
      @(posedge clk); #1;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_start_busy got=%b exp=0", bus.busy); end
   endtask

   task automatic test_basic();
      int c;
      do_op(4'b0101, 4'b0000, 1'b0, c);
      total++; if (c != 5) begin bad++; $display("FAIL lat1 got=%0d exp=5", c); end
      total++; if (bus.diff !== 4'b0101) begin bad++; $display("FAIL diff1 got=%b exp=0101", bus.diff); end
      total++; if (bus.borrow !== 1'b0) begin bad++; $display("FAIL borrow1 got=%b exp=0", bus.borrow); end
      @(posedge clk); #1;
      do_op(4'b0110, 4'b0101, 1'b1, c);
      total++; if (c != 5) begin bad++; $display("FAIL lat2 got=%0d exp=5", c); end
      total++; if (bus.diff !== 4'b0000) begin bad++; $display("FAIL diff2 got=%b exp=0000", bus.diff); end
      total++; if (bus.borrow !== 1'b0) begin bad++; $display("FAIL borrow2 got=%b exp=0", bus.borrow); end
      @(posedge clk); #1;
      do_op(4'b0110, 4'b1111, 1'b0, c);
      total++; if (bus.diff !== 4'b0111) begin bad++; $display("FAIL diff3 got=%b exp=0111", bus.diff); end
      total++; if (bus.borrow !== 1'b1) begin bad++; $display("FAIL borrow3 got=%b exp=1", bus.borrow); end
      @(posedge clk); #1;
   endtask

   task automatic test_hold();
      int c;
      do_op(4'b1111, 4'b1111, 1'b1, c);
      total++; if (bus.diff !== 4'b1111) begin bad++; $display("FAIL diff4 got=%b exp=1111", bus.diff); end
      total++; if (bus.borrow !== 1'b1) begin bad++; $display("FAIL borrow4 got=%b exp=1", bus.borrow); end
      for (int i = 0; i < 10; i++) begin
         bus.a = 4'($urandom); bus.b = 4'($urandom); bus.b_in = 1'($urandom);
         @(posedge clk); #1;
         total++;
         if (bus.diff !== 4'b1111 || bus.borrow !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL hold%0d got diff=%b borrow=%b done=%b busy=%b exp 1111/1/0/0",
                     i, bus.diff, bus.borrow, bus.done, bus.busy);
         end
      end
   endtask

   task automatic test_start_while_busy();
      int pulses;
      int c;
      bus.a = 4'b0011; bus.b = 4'b0001; bus.b_in = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      // keep start high with new operands through RUN and the done cycle
      bus.a = 4'b1111; bus.b = 4'b0000;
      pulses = 0;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) pulses++;
      end
      total++; if (pulses != 1) begin bad++; $display("FAIL busy_pulses got=%0d exp=1", pulses); end
      total++; if (bus.diff !== 4'b0010) begin bad++; $display("FAIL busy_diff got=%b exp=0010", bus.diff); end
      @(posedge clk); #1;
      total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         bad++; $display("FAIL done_start_ignored got busy=%b done=%b exp 0/0", bus.busy, bus.done);
      end
      total++; if (bus.diff !== 4'b0010) begin bad++; $display("FAIL idle_diff got=%b exp=0010", bus.diff); end
      @(posedge clk); #1;
      bus.start = 1'b0;
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL idle_accept got=%b exp=1", bus.busy); end
      c = 1;
      while (bus.done !== 1'b1 && c < 20) begin @(posedge clk); #1; c++; end
      total++; if (c != 5) begin bad++; $display("FAIL lat5 got=%0d exp=5", c); end
      total++; if (bus.diff !== 4'b1111 || bus.borrow !== 1'b0) begin
         bad++; $display("FAIL diff5 got=%b/%b exp=1111/0", bus.diff, bus.borrow);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int pulses;
      int c;
      bus.a = 4'b0010; bus.b = 4'b0101; bus.b_in = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
      total++; if (bus.diff !== 4'b0000) begin bad++; $display("FAIL mid_diff got=%b exp=0000", bus.diff); end
      total++; if (bus.borrow !== 1'b0) begin bad++; $display("FAIL mid_borrow got=%b exp=0", bus.borrow); end
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.done === 1'b1) pulses++;
         @(posedge clk); #1;
      end
      total++; if (pulses != 0) begin bad++; $display("FAIL mid_done got=%0d exp=0", pulses); end
      do_op(4'b1000, 4'b0001, 1'b0, c);
      total++; if (c != 5) begin bad++; $display("FAIL lat6 got=%0d exp=5", c); end
      total++; if (bus.diff !== 4'b0111 || bus.borrow !== 1'b0) begin
         bad++; $display("FAIL diff6 got=%b/%b exp=0111/0", bus.diff, bus.borrow);
      end
`ifdef SERIAL_SUB_OVF_EN
      total++; if (bus.ovf !== 1'b1) begin bad++; $display("FAIL ovf1 got=%b exp=1", bus.ovf); end
`endif
      @(posedge clk); #1;
   endtask

`ifdef SERIAL_SUB_OVF_EN
   task automatic test_ovf();
      int c;
      do_op(4'b0110, 4'b1111, 1'b0, c);
      total++; if (bus.diff !== 4'b0111 || bus.ovf !== 1'b0) begin
         bad++; $display("FAIL ovf2 got=%b/%b exp=0111/0", bus.diff, bus.ovf);
      end
      @(posedge clk); #1;
      do_op(4'b1000, 4'b0001, 1'b0, c);
      total++; if (bus.diff !== 4'b0111 || bus.ovf !== 1'b1) begin
         bad++; $display("FAIL ovf3 got=%b/%b exp=0111/1", bus.diff, bus.ovf);
      end
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_basic();
      test_hold();
      test_start_while_busy();
      test_reset_mid();
`ifdef SERIAL_SUB_OVF_EN
      test_ovf();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
